// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory controller for the MESI bus system.
// Bus requests enter an in-order queue and are serviced one at a time from IDLE.
// WB writes the line, UPGR is dropped, and RD/RDX read the line, wait RD_LAT cycles,
// then return it over a valid/ready response channel.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready/op/addr/src/data  request channel (op: 0=RD 1=RDX 2=WB 3=UPGR)
//   rsp_valid/ready/addr/data/dest    read-response channel toward the crossbar
//   q_count                       request-queue occupancy
//   busy                          FSM active or queue non-empty
module mem_ctrl #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned LINE_W  = 32,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned Q_DEPTH = 4,
    localparam int unsigned SRC_W  = $clog2(NUM_SRC),
    localparam int unsigned CNT_W  = $clog2(Q_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [SRC_W-1:0]  req_src,
    input  logic [LINE_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [LINE_W-1:0] rsp_data,
    output logic [SRC_W-1:0]  rsp_dest,
    output logic [CNT_W-1:0]  q_count,
    output logic              busy
);

    localparam int unsigned MEM_LINES = 2 ** ADDR_W;
    localparam int unsigned PTR_W     = $clog2(Q_DEPTH);
    localparam int unsigned LAT_W     = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam int unsigned ENT_W     = 2 + ADDR_W + SRC_W + LINE_W;

    localparam logic [1:0] OP_RD   = 2'd0;
    localparam logic [1:0] OP_RDX  = 2'd1;
    localparam logic [1:0] OP_WB   = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [LINE_W-1:0]  mem   [MEM_LINES];
    logic [ENT_W-1:0]   q_mem [Q_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [LAT_W-1:0]   cnt;

    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   head_ent;
    logic [1:0]         head_op;
    logic [ADDR_W-1:0]  head_addr;
    logic [SRC_W-1:0]   head_src;
    logic [LINE_W-1:0]  head_data;

    // Circular pointer advance that also handles non-power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered count, so a same-edge pop never un-blocks a full queue
    assign req_ready = (q_count < CNT_W'(Q_DEPTH));
    assign busy      = (state != IDLE) || (q_count != '0);

    assign push = req_valid && req_ready;
    assign pop  = (state == IDLE) && (q_count != '0);

    // Head-entry field split
    assign head_ent  = q_mem[head];
    assign head_op   = head_ent[ENT_W-1 -: 2];
    assign head_addr = head_ent[ADDR_W+SRC_W+LINE_W-1 -: ADDR_W];
    assign head_src  = head_ent[SRC_W+LINE_W-1 -: SRC_W];
    assign head_data = head_ent[LINE_W-1:0];

    // Queue, memory array and service FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LINES; i++) begin
                mem[i] <= LINE_W'(i);
            end
            head      <= '0;
            tail      <= '0;
            q_count   <= '0;
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_dest  <= '0;
        end else begin
            if (push) begin
                q_mem[tail] <= {req_op, req_addr, req_src, req_data};
                tail        <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                q_count <= q_count + CNT_W'(1);
            end else if (!push && pop) begin
                q_count <= q_count - CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        case (head_op)
                            OP_WB: mem[head_addr] <= head_data;
                            OP_RD, OP_RDX: begin
                                // Data is frozen at pop; later WBs wait until we are back in IDLE
                                rsp_addr <= head_addr;
                                rsp_dest <= head_src;
                                rsp_data <= mem[head_addr];
                                if (RD_LAT == 0) begin
                                    state     <= RESP;
                                    rsp_valid <= 1'b1;
                                end else begin
                                    state <= WAIT;
                                    cnt   <= LAT_W'(RD_LAT);
                                end
                            end
                            default: ; // UPGR needs no memory action
                        endcase
                    end
                end
                WAIT: begin
                    if (cnt == LAT_W'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: scoreboard of expected read responses built from a
// reference memory model at enqueue time, checked by a response monitor.
module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned LINE_W = 32;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] OP_RD   = 2'd0;
    localparam logic [1:0] OP_RDX  = 2'd1;
    localparam logic [1:0] OP_WB   = 2'd2;
    localparam logic [1:0] OP_UPGR = 2'd3;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [SRC_W-1:0]  req_src;
    logic [LINE_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [LINE_W-1:0] rsp_data;
    logic [SRC_W-1:0]  rsp_dest;
    logic [CNT_W-1:0]  q_count;
    logic              busy;

    mem_ctrl #(
        .NUM_SRC(4), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .RD_LAT(2), .Q_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_src(req_src), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_dest(rsp_dest),
        .q_count(q_count), .busy(busy)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic [SRC_W-1:0]  dest;
    } exp_t;

    int          n_cmp;
    int          n_fail;
    int          n_rsp;
    exp_t        sb[$];
    logic [LINE_W-1:0] ref_mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response monitor: every handshake must match the scoreboard head
    always @(posedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            n_rsp++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got addr=%0h data=%0h dest=%0d, required none",
                         rsp_addr, rsp_data, rsp_dest);
            end else begin
                e = sb.pop_front();
                if ({rsp_addr, rsp_data, rsp_dest} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_payload: got addr=%0h data=%0h dest=%0d, required addr=%0h data=%0h dest=%0d",
                             rsp_addr, rsp_data, rsp_dest, e.addr, e.data, e.dest);
                end
            end
        end
    end

    task automatic model_init();
        sb.delete();
        for (int i = 0; i < 16; i++) ref_mem[i] = LINE_W'(i);
    endtask

    // Drive one request and hold it until accepted; track=0 keeps it out of the model
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [SRC_W-1:0] s, input logic [LINE_W-1:0] d, input bit track);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_src   = s;
        req_data  = d;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                if (track) begin
                    if (op == OP_RD || op == OP_RDX) sb.push_back('{a, ref_mem[a], s});
                    else if (op == OP_WB) ref_mem[a] = d;
                end
                return;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: req_ready stayed %0b, required 1", req_ready);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (sb.size() == 0 && !busy && !rsp_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d busy=%0b, required pending=0 busy=0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_src   = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
        n_cmp++;
        if ({q_count, rsp_valid, req_ready, busy} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got q_count=%0d rsp_valid=%0b req_ready=%0b busy=%0b, required 0 0 1 0",
                     q_count, rsp_valid, req_ready, busy);
        end
        n_cmp++;
        if ({rsp_addr, rsp_data, rsp_dest} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp_regs: got addr=%0h data=%0h dest=%0d, required 0",
                     rsp_addr, rsp_data, rsp_dest);
        end
    endtask

    task automatic test_read_latency();
        int n = 0;
        rsp_ready = 1'b1;
        send(OP_RD, 4'd5, 2'd2, '0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d cycles, required 3", n);
        end
        drain();
    endtask

    task automatic test_wb_then_rd();
        int base = n_rsp;
        rsp_ready = 1'b1;
        send(OP_WB, 4'd3, 2'd1, 32'hDEAD, 1'b1);
        send(OP_RD, 4'd3, 2'd1, '0, 1'b1);
        drain();
        n_cmp++;
        if (n_rsp - base !== 1) begin
            n_fail++;
            $display("FAIL wb_rd_count: got %0d responses, required 1", n_rsp - base);
        end
    endtask

    task automatic test_stall();
        int base = n_rsp;
        bit seen = 1'b0;
        rsp_ready = 1'b0;
        send(OP_RDX, 4'd9, 2'd3, '0, 1'b1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = rsp_valid;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({rsp_valid, rsp_addr, rsp_data, rsp_dest} !== {1'b1, 4'd9, 32'd9, 2'd3}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b addr=%0h data=%0h dest=%0d, required v=1 addr=9 data=9 dest=3",
                         i, rsp_valid, rsp_addr, rsp_data, rsp_dest);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        drain();
        n_cmp++;
        if (n_rsp - base !== 1) begin
            n_fail++;
            $display("FAIL stall_count: got %0d responses, required 1", n_rsp - base);
        end
    endtask

    task automatic test_back_to_back();
        int base = n_rsp;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send((i % 2 == 0) ? OP_RD : OP_RDX, ADDR_W'(i), SRC_W'(i), '0, 1'b1);
        end
        // Sixth request must be held off while the queue is full
        req_valid = 1'b1;
        req_op    = OP_RD;
        req_addr  = 4'd5;
        req_src   = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({q_count, req_ready} !== {3'd4, 1'b0}) begin
                n_fail++;
                $display("FAIL full_hold[%0d]: got q_count=%0d req_ready=%0b, required 4 0",
                         i, q_count, req_ready);
            end
        end
        rsp_ready = 1'b1;
        send(OP_RD, 4'd5, 2'd1, '0, 1'b1);
        drain();
        n_cmp++;
        if (n_rsp - base !== 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, required 6", n_rsp - base);
        end
    endtask

    task automatic test_upgrade();
        int base = n_rsp;
        rsp_ready = 1'b1;
        send(OP_UPGR, 4'd7, 2'd0, 32'hFFFF_FFFF, 1'b1);
        send(OP_RD, 4'd7, 2'd0, '0, 1'b1);
        drain();
        n_cmp++;
        if (n_rsp - base !== 1) begin
            n_fail++;
            $display("FAIL upgr_count: got %0d responses, required 1", n_rsp - base);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        rsp_ready = 1'b1;
        // RD goes into WAIT while the WB sits queued; neither is tracked
        send(OP_RD, 4'd10, 2'd2, '0, 1'b0);
        send(OP_WB, 4'd3, 2'd0, 32'hBEEF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
        base = n_rsp;
        n_cmp++;
        if ({q_count, rsp_valid, busy} !== {3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_state: got q_count=%0d rsp_valid=%0b busy=%0b, required 0 0 0",
                     q_count, rsp_valid, busy);
        end
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_rsp - base !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_rsp: got %0d responses, required 0", n_rsp - base);
        end
        send(OP_RD, 4'd3, 2'd3, '0, 1'b1);
        drain();
        n_cmp++;
        if (n_rsp - base !== 1) begin
            n_fail++;
            $display("FAIL midrst_reread: got %0d responses, required 1", n_rsp - base);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        n_rsp  = 0;
        test_reset();
        test_read_latency();
        test_wb_then_rd();
        test_stall();
        test_back_to_back();
        test_upgrade();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
